// File: rtl/proc_io_port.sv
`default_nettype none
// ============================================================================
// proc_io_port: per-channel input FIFOs popped by a soft core, plus latched
// output registers with update strobes and a maskable data-pending interrupt.
// Revision: 1.0
// ============================================================================
module proc_io_port #(
    parameter int DATA_W     = 32,
    parameter int N_IN       = 2,
    parameter int N_OUT      = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_geral_n,
    input  logic [N_IN*DATA_W-1:0]   in_data,
    input  logic [N_IN-1:0]          in_valid,
    output logic [N_IN-1:0]          in_ready,
    input  logic [N_IN-1:0]          req_in,
    output logic signed [DATA_W-1:0] io_in,
    output logic                     stall,
    output logic                     req_err,
    input  logic signed [DATA_W-1:0] out_proc,
    input  logic [N_OUT-1:0]         out_en,
    output logic [N_OUT*DATA_W-1:0]  out_data,
    output logic [N_OUT-1:0]         out_strobe,
    input  logic [N_IN-1:0]          itr_mask,
    output logic                     itr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [N_IN-1:0]        empty;
    logic [N_IN-1:0]        full;
    logic [N_IN-1:0]        push;
    logic [N_IN-1:0]        pop;
    logic [N_IN*DATA_W-1:0] heads;
    logic                   req_any;
    logic                   req_multi;
    logic                   req_onehot;
    logic [DATA_W-1:0]      sel_head;
    logic                   sel_empty;

    // Clearing the lowest set bit leaves something only when two or more bits are set.
    assign req_any    = |req_in;
    assign req_multi  = |(req_in & (req_in - N_IN'(1)));
    assign req_onehot = req_any & ~req_multi;

    always_comb begin
        sel_head  = '0;
        sel_empty = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            if (req_in[k]) begin
                sel_head  = heads[k*DATA_W +: DATA_W];
                sel_empty = empty[k];
            end
        end
    end

    assign io_in    = (req_onehot && !sel_empty) ? sel_head : '0;
    assign stall    = req_onehot & sel_empty;
    assign in_ready = ~full;
    assign push     = in_valid & ~full;
    assign pop      = {N_IN{req_onehot}} & req_in & ~empty;

    generate
        for (genvar k = 0; k < N_IN; k++) begin : g_fifo
            logic [DATA_W-1:0] mem [FIFO_DEPTH];
            logic [AW-1:0]     wr_ptr;
            logic [AW-1:0]     rd_ptr;
            logic [CW-1:0]     count;

            always_ff @(posedge clk) begin
                if (push[k]) mem[wr_ptr] <= in_data[k*DATA_W +: DATA_W];
            end

            // Pointers wrap naturally because the depth is a power of two.
            always_ff @(posedge clk or negedge rst_geral_n) begin
                if (!rst_geral_n) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                end else begin
                    if (push[k]) wr_ptr <= wr_ptr + AW'(1);
                    if (pop[k])  rd_ptr <= rd_ptr + AW'(1);
                    case ({push[k], pop[k]})
                        2'b10:   count <= count + CW'(1);
                        2'b01:   count <= count - CW'(1);
                        default: count <= count;
                    endcase
                end
            end

            assign empty[k]                   = (count == '0);
            assign full[k]                    = (count == CW'(FIFO_DEPTH));
            assign heads[k*DATA_W +: DATA_W]  = mem[rd_ptr];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_geral_n) begin
        if (!rst_geral_n) begin
            out_data   <= '0;
            out_strobe <= '0;
            req_err    <= 1'b0;
            itr        <= 1'b0;
        end else begin
            for (int j = 0; j < N_OUT; j++) begin
                if (out_en[j]) out_data[j*DATA_W +: DATA_W] <= out_proc;
            end
            out_strobe <= out_en;
            req_err    <= req_multi;
            itr        <= |(~empty & itr_mask);
        end
    end

endmodule
`default_nettype wire
